// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-control struct for the ID stage.
package decode_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_NOR  = 4'b1100,
      ALU_NONE = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_BEQ  = 2'b01,
      JMP_J    = 2'b10,
      JMP_JR   = 2'b11
   } jump_type_e;

   typedef enum logic [1:0] {
      RDS_ALU  = 2'b00,
      RDS_DMEM = 2'b01,
      RDS_LINK = 2'b10
   } reg_data_sel_e;

   typedef enum logic [1:0] {
      SSEL_NONE = 2'b00,
      SSEL_RS2  = 2'b01,
      SSEL_IMM  = 2'b11
   } ssel_e;

   // Width-independent decode result; imm/jump_addr/pc travel alongside it.
   typedef struct packed {
      jump_type_e    jump_type;
      logic          we_dmem;
      logic          we_regfile;
      alu_op_e       op;
      ssel_e         ssel;
      logic [4:0]    rs1_id;
      logic [4:0]    rs2_id;
      logic [4:0]    rdst_id;
      reg_data_sel_e reg_data_sel;
      logic          illegal;
      logic          is_load;
   } ctrl_t;

   function automatic ctrl_t ctrl_nop();
      ctrl_t c;
      c.jump_type    = JMP_NONE;
      c.we_dmem      = 1'b0;
      c.we_regfile   = 1'b0;
      c.op           = ALU_NONE;
      c.ssel         = SSEL_NONE;
      c.rs1_id       = 5'd0;
      c.rs2_id       = 5'd0;
      c.rdst_id      = 5'd0;
      c.reg_data_sel = RDS_ALU;
      c.illegal      = 1'b0;
      c.is_load      = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_logic.sv
// Pure combinational instruction decoder: instruction + pc -> control, imm, target.
module decode_logic
   import decode_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 32,
   parameter int LINK_REG = 31
) (
   input  logic [DWIDTH-1:0] instr,
   input  logic [AWIDTH-1:0] pc,
   output ctrl_t             ctrl,
   output logic [DWIDTH-1:0] imm,
   output logic [AWIDTH-1:0] jump_addr
);

   logic [5:0]        opc;
   logic [5:0]        fn;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [AWIDTH-1:0] pc4;
   logic [AWIDTH-1:0] br_off;
   logic [AWIDTH-1:0] j_tgt;

   assign opc    = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign fn     = instr[5:0];
   assign imm    = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
   assign pc4    = pc + AWIDTH'(4);
   assign br_off = {{(AWIDTH-18){instr[15]}}, instr[15:0], 2'b00};

   // Region bits above 28 come from pc+4; works for any AWIDTH >= 28.
   always_comb begin
      j_tgt       = pc4;
      j_tgt[27:0] = {instr[25:0], 2'b00};
   end

   always_comb begin
      ctrl      = ctrl_nop();
      jump_addr = '0;
      if (instr != '0) begin
         case (opc)
            OPC_RTYPE: begin
               if (fn == FN_JR) begin
                  ctrl.jump_type = JMP_JR;
                  ctrl.rs1_id    = rs;
               end else begin
                  ctrl.we_regfile = 1'b1;
                  ctrl.ssel       = SSEL_RS2;
                  ctrl.rs1_id     = rs;
                  ctrl.rs2_id     = rt;
                  ctrl.rdst_id    = rd;
                  case (fn)
                     FN_ADD:  ctrl.op = ALU_ADD;
                     FN_SUB:  ctrl.op = ALU_SUB;
                     FN_AND:  ctrl.op = ALU_AND;
                     FN_OR:   ctrl.op = ALU_OR;
                     FN_NOR:  ctrl.op = ALU_NOR;
                     FN_SLT:  ctrl.op = ALU_SLT;
                     default: begin
                        ctrl         = ctrl_nop();
                        ctrl.illegal = 1'b1;
                     end
                  endcase
               end
            end
            OPC_ADDI, OPC_SLTI: begin
               ctrl.op         = (opc == OPC_ADDI) ? ALU_ADD : ALU_SLT;
               ctrl.ssel       = SSEL_IMM;
               ctrl.we_regfile = 1'b1;
               ctrl.rs1_id     = rs;
               ctrl.rdst_id    = rt;
            end
            OPC_LW: begin
               ctrl.op           = ALU_ADD;
               ctrl.ssel         = SSEL_IMM;
               ctrl.we_regfile   = 1'b1;
               ctrl.reg_data_sel = RDS_DMEM;
               ctrl.rs1_id       = rs;
               ctrl.rdst_id      = rt;
               ctrl.is_load      = 1'b1;
            end
            OPC_SW: begin
               ctrl.op      = ALU_ADD;
               ctrl.ssel    = SSEL_IMM;
               ctrl.we_dmem = 1'b1;
               ctrl.rs1_id  = rs;
               ctrl.rs2_id  = rt;
            end
            OPC_BEQ: begin
               ctrl.op        = ALU_SUB;
               ctrl.ssel      = SSEL_RS2;
               ctrl.jump_type = JMP_BEQ;
               ctrl.rs1_id    = rs;
               ctrl.rs2_id    = rt;
               jump_addr      = pc4 + br_off;
            end
            OPC_J, OPC_JAL: begin
               ctrl.jump_type = JMP_J;
               jump_addr      = j_tgt;
               if (opc == OPC_JAL) begin
                  ctrl.we_regfile   = 1'b1;
                  ctrl.rdst_id      = 5'(LINK_REG);
                  ctrl.reg_data_sel = RDS_LINK;
               end
            end
            default: ctrl.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/decode_stage.sv
// ID stage: registered decode slot with valid/ready, load-use bubbling and flush.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 32,
   parameter int LINK_REG    = 31,
   parameter int EN_LOAD_USE = 1,
   parameter int CWIDTH      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_instr,
   input  logic [AWIDTH-1:0] in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AWIDTH-1:0] out_pc,
   output logic [1:0]        jump_type,
   output logic [AWIDTH-1:0] jump_addr,
   output logic              we_dmem,
   output logic              we_regfile,
   output logic [3:0]        op,
   output logic [1:0]        ssel,
   output logic [DWIDTH-1:0] imm,
   output logic [4:0]        rs1_id,
   output logic [4:0]        rs2_id,
   output logic [4:0]        rdst_id,
   output logic [1:0]        reg_data_sel,
   output logic              illegal,
   output logic [CWIDTH-1:0] bubble_cnt
);

   ctrl_t             dec;
   ctrl_t             slot;
   logic [DWIDTH-1:0] dec_imm;
   logic [DWIDTH-1:0] slot_imm;
   logic [AWIDTH-1:0] dec_jaddr;
   logic [AWIDTH-1:0] slot_jaddr;
   logic [AWIDTH-1:0] slot_pc;
   logic              slot_valid;
   logic              hazard;
   logic [CWIDTH-1:0] cnt;

   decode_logic #(
      .DWIDTH  (DWIDTH),
      .AWIDTH  (AWIDTH),
      .LINK_REG(LINK_REG)
   ) u_dec (
      .instr    (in_instr),
      .pc       (in_pc),
      .ctrl     (dec),
      .imm      (dec_imm),
      .jump_addr(dec_jaddr)
   );

   // Unused source ids decode to 0, and a zero destination never matches.
   generate
      if (EN_LOAD_USE != 0) begin : g_hazard
         logic dep;
         assign dep    = (dec.rs1_id == slot.rdst_id) | (dec.rs2_id == slot.rdst_id);
         assign hazard = slot_valid & slot.is_load & (slot.rdst_id != 5'd0) & in_valid & dep;
      end else begin : g_no_hazard
         assign hazard = 1'b0;
      end
   endgenerate

   assign in_ready = flush | ((~slot_valid | out_ready) & ~hazard);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= 1'b0;
         slot       <= ctrl_nop();
         slot_imm   <= '0;
         slot_jaddr <= '0;
         slot_pc    <= '0;
         cnt        <= '0;
      end else if (flush) begin
         slot_valid <= 1'b0;
      end else if (in_valid & in_ready) begin
         slot_valid <= 1'b1;
         slot       <= dec;
         slot_imm   <= dec_imm;
         slot_jaddr <= dec_jaddr;
         slot_pc    <= in_pc;
      end else if (out_ready) begin
         slot_valid <= 1'b0;
         if (hazard && cnt != '1)
            cnt <= cnt + CWIDTH'(1);
      end
   end

   assign out_valid    = slot_valid;
   assign out_pc       = slot_pc;
   assign jump_type    = slot.jump_type;
   assign jump_addr    = slot_jaddr;
   assign we_dmem      = slot.we_dmem;
   assign we_regfile   = slot.we_regfile;
   assign op           = slot.op;
   assign ssel         = slot.ssel;
   assign imm          = slot_imm;
   assign rs1_id       = slot.rs1_id;
   assign rs2_id       = slot.rs2_id;
   assign rdst_id      = slot.rdst_id;
   assign reg_data_sel = slot.reg_data_sel;
   assign illegal      = slot.illegal;
   assign bubble_cnt   = cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised + directed bench for decode_stage against an instruction-level reference model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, we_dmem, we_regfile, illegal;
   logic [31:0] out_pc, jump_addr, imm;
   logic [1:0]  jump_type, ssel, reg_data_sel;
   logic [3:0]  op;
   logic [4:0]  rs1_id, rs2_id, rdst_id;
   logic [1:0]  bubble_cnt;

   logic        in_ready_b, out_valid_b, we_dmem_b, we_regfile_b, illegal_b;
   logic [31:0] out_pc_b, jump_addr_b, imm_b;
   logic [1:0]  jump_type_b, ssel_b, reg_data_sel_b;
   logic [3:0]  op_b;
   logic [4:0]  rs1_id_b, rs2_id_b, rdst_id_b;
   logic [1:0]  bubble_cnt_b;

   always #5 clk = ~clk;

   decode_stage #(.DWIDTH(32), .AWIDTH(32), .LINK_REG(31), .EN_LOAD_USE(1), .CWIDTH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .jump_type(jump_type), .jump_addr(jump_addr), .we_dmem(we_dmem),
      .we_regfile(we_regfile), .op(op), .ssel(ssel), .imm(imm), .rs1_id(rs1_id),
      .rs2_id(rs2_id), .rdst_id(rdst_id), .reg_data_sel(reg_data_sel), .illegal(illegal),
      .bubble_cnt(bubble_cnt));

   decode_stage #(.DWIDTH(32), .AWIDTH(32), .LINK_REG(31), .EN_LOAD_USE(0), .CWIDTH(2)) dut_nohz (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_pc(out_pc_b), .jump_type(jump_type_b), .jump_addr(jump_addr_b), .we_dmem(we_dmem_b),
      .we_regfile(we_regfile_b), .op(op_b), .ssel(ssel_b), .imm(imm_b), .rs1_id(rs1_id_b),
      .rs2_id(rs2_id_b), .rdst_id(rdst_id_b), .reg_data_sel(reg_data_sel_b), .illegal(illegal_b),
      .bubble_cnt(bubble_cnt_b));

   typedef struct {
      logic [1:0]  jt;
      logic [31:0] ja;
      logic        wd;
      logic        wr;
      logic [3:0]  op;
      logic [1:0]  ss;
      logic [31:0] imm;
      logic [4:0]  r1, r2, rd;
      logic [1:0]  rds;
      logic        ill;
   } exp_t;

   int checks = 0;
   int errors = 0;

   // reference slot: raw instruction word + pc, decoded on demand
   logic        m_valid = 1'b0;
   logic [31:0] m_ins = '0;
   logic [31:0] m_pc = '0;
   int          m_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t decode_ref(input logic [31:0] ins, input logic [31:0] p);
      exp_t e;
      logic [5:0] opc = ins[31:26];
      logic [5:0] fn = ins[5:0];
      logic [31:0] pc4 = p + 32'd4;
      e.jt = 2'b00; e.ja = '0; e.wd = 0; e.wr = 0; e.op = 4'hF; e.ss = 2'b00;
      e.imm = {{16{ins[15]}}, ins[15:0]};
      e.r1 = 0; e.r2 = 0; e.rd = 0; e.rds = 2'b00; e.ill = 0;
      if (ins == 32'h0) return e;
      if (opc == 6'h00 && fn == 6'h08) begin
         e.jt = 2'b11; e.r1 = ins[25:21];
      end else if (opc == 6'h00) begin
         case (fn)
            6'h20: e.op = 4'b0010;
            6'h22: e.op = 4'b0110;
            6'h24: e.op = 4'b0000;
            6'h25: e.op = 4'b0001;
            6'h27: e.op = 4'b1100;
            6'h2A: e.op = 4'b0111;
            default: e.ill = 1;
         endcase
         if (!e.ill) begin
            e.wr = 1; e.ss = 2'b01; e.r1 = ins[25:21]; e.r2 = ins[20:16]; e.rd = ins[15:11];
         end
      end else if (opc == 6'h08 || opc == 6'h0A) begin
         e.op = (opc == 6'h08) ? 4'b0010 : 4'b0111;
         e.ss = 2'b11; e.wr = 1; e.r1 = ins[25:21]; e.rd = ins[20:16];
      end else if (opc == 6'h23) begin
         e.op = 4'b0010; e.ss = 2'b11; e.wr = 1; e.rds = 2'b01; e.r1 = ins[25:21]; e.rd = ins[20:16];
      end else if (opc == 6'h2B) begin
         e.op = 4'b0010; e.ss = 2'b11; e.wd = 1; e.r1 = ins[25:21]; e.r2 = ins[20:16];
      end else if (opc == 6'h04) begin
         e.op = 4'b0110; e.ss = 2'b01; e.jt = 2'b01; e.r1 = ins[25:21]; e.r2 = ins[20:16];
         e.ja = pc4 + (e.imm << 2);
      end else if (opc == 6'h02 || opc == 6'h03) begin
         e.jt = 2'b10; e.ja = {pc4[31:28], ins[25:0], 2'b00};
         if (opc == 6'h03) begin e.wr = 1; e.rd = 5'd31; e.rds = 2'b10; end
      end else begin
         e.ill = 1;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs = 5'($urandom_range(0, 3));
      logic [4:0]  rt = 5'($urandom_range(0, 3));
      logic [4:0]  rd = 5'($urandom_range(0, 3));
      logic [15:0] i16 = 16'($urandom);
      logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      case ($urandom_range(0, 13))
         0, 13:   return {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
         1:       return {6'h00, rs, 15'd0, 6'h08};
         2:       return {6'h08, rs, rt, i16};
         3:       return {6'h0A, rs, rt, i16};
         4, 5:    return {6'h23, rs, rt, i16};
         6:       return {6'h2B, rs, rt, i16};
         7:       return {6'h04, rs, rt, i16};
         8:       return {6'h02, 26'($urandom)};
         9:       return {6'h03, 26'($urandom)};
         10:      return 32'h0;
         11:      return {6'h3F, 26'($urandom)};
         default: return {6'h00, rs, rt, rd, 5'd0, 6'h3F};
      endcase
   endfunction

   // One clock: drive inputs after the edge, check at negedge, advance the model.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic ordy, input logic fl, input logic r);
      exp_t e, di;
      logic hz, er;
      @(posedge clk); #1;
      in_valid = v; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; rst = r;
      @(negedge clk);
      e = decode_ref(m_ins, m_pc);
      check("out_valid", out_valid, m_valid);
      check("bubble_cnt", bubble_cnt, m_cnt);
      check("out_pc", out_pc, m_pc);
      check("jump_type", jump_type, e.jt);
      check("jump_addr", jump_addr, e.ja);
      check("we_dmem", we_dmem, e.wd);
      check("we_regfile", we_regfile, e.wr);
      check("op", op, e.op);
      check("ssel", ssel, e.ss);
      check("imm", imm, e.imm);
      check("rs1_id", rs1_id, e.r1);
      check("rs2_id", rs2_id, e.r2);
      check("rdst_id", rdst_id, e.rd);
      check("reg_data_sel", reg_data_sel, e.rds);
      check("illegal", illegal, e.ill);
      di = decode_ref(ins, p);
      hz = m_valid && m_ins[31:26] == 6'h23 && m_ins[20:16] != 5'd0 && v &&
           (di.r1 == m_ins[20:16] || di.r2 == m_ins[20:16]);
      er = fl || ((!m_valid || ordy) && !hz);
      check("in_ready", in_ready, er);
      if (r) begin
         m_valid = 0; m_ins = '0; m_pc = '0; m_cnt = 0;
      end else if (fl) begin
         m_valid = 0;
      end else if (v && er) begin
         m_valid = 1; m_ins = ins; m_pc = p;
      end else if (ordy) begin
         if (hz && m_cnt < 3) m_cnt++;
         m_valid = 0;
      end
   endtask

   initial begin
      step(0, 32'h0, 32'h0, 1, 0, 1);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("rst_op", op, 4'hF);

      // basic R-type
      step(1, 32'h00221820, 32'h0, 1, 0, 0);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("add_op", op, 4'b0010);
      check("add_rdst", rdst_id, 5'd3);
      check("add_ssel", ssel, 2'b01);

      // load-use: exactly one bubble
      step(1, 32'h8C220004, 32'h4, 1, 0, 0);
      step(1, 32'h00441820, 32'h8, 1, 0, 0);
      check("lu_stall", in_ready, 1'b0);
      step(1, 32'h00441820, 32'h8, 1, 0, 0);
      check("lu_bubble", out_valid, 1'b0);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("lu_add_pc", out_pc, 32'h8);
      check("lu_cnt", bubble_cnt, 2'd1);

      // branch and jal targets
      step(1, 32'h1022FFFF, 32'h10, 1, 0, 0);
      step(1, 32'h0C000100, 32'h40, 1, 0, 0);
      check("beq_jt", jump_type, 2'b01);
      check("beq_addr", jump_addr, 32'h10);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("jal_addr", jump_addr, 32'h400);
      check("jal_rdst", rdst_id, 5'd31);
      check("jal_rds", reg_data_sel, 2'b10);

      // backpressure for 3 cycles, then release
      step(1, 32'h00221820, 32'h50, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h00852022, 32'h54, 0, 0, 0);
      step(1, 32'h00852022, 32'h54, 1, 0, 0);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("bp_pc", out_pc, 32'h54);

      // flush with a valid slot and a valid input
      step(1, 32'h00221820, 32'h60, 0, 0, 0);
      step(1, 32'h00852022, 32'h64, 0, 1, 0);
      check("fl_ready", in_ready, 1'b1);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("fl_valid", out_valid, 1'b0);

      // illegal opcode, then reset mid-stream
      step(1, 32'hFC000000, 32'h70, 1, 0, 0);
      step(1, 32'h00221820, 32'h74, 1, 0, 0);
      check("ill_flag", illegal, 1'b1);
      check("ill_op", op, 4'hF);
      check("ill_we", we_regfile, 1'b0);
      step(1, 32'h00221820, 32'h78, 1, 0, 1);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_cnt", bubble_cnt, 2'd0);

      // bubble counter saturation
      for (int i = 0; i < 5; i++) begin
         step(1, 32'h8C220004, 32'h80, 1, 0, 0);
         step(1, 32'h00441820, 32'h84, 1, 0, 0);
         step(1, 32'h00441820, 32'h84, 1, 0, 0);
      end
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("sat_cnt", bubble_cnt, 2'd3);

      // randomised traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom_range(0, 9) < 7,
              $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);

      // hazard logic tied off: add follows lw back to back
      step(0, 32'h0, 32'h0, 1, 0, 1);
      step(1, 32'h8C220004, 32'h90, 1, 0, 0);
      step(1, 32'h00441820, 32'h94, 1, 0, 0);
      check("nohz_ready", in_ready_b, 1'b1);
      check("nohz_lw", rdst_id_b, 5'd2);
      step(0, 32'h0, 32'h0, 1, 0, 0);
      check("nohz_valid", out_valid_b, 1'b1);
      check("nohz_add_pc", out_pc_b, 32'h94);
      check("nohz_cnt", bubble_cnt_b, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
